// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared types, constants and address decode for the register-bank write path
package regbank_pkg;

    localparam int REG_DW   = 10;
    localparam int MAX_REGS = 512;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Decode is wider than any legal bank so out-of-range indices land above NREGS and can be detected.
    function automatic logic [MAX_REGS-1:0] onehot_dec(input logic [8:0] idx);
        logic [MAX_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regbank_write_arbiter_rr_pick.sv
// rtl/regbank_write_arbiter_rr_pick.sv - combinational round-robin winner select
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [PW-1:0]   winner,
    output logic            valid
);

    int   idx;
    logic found;

    // First set bit scanning upward from rr_ptr, wrapping at NREQ-1.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(rr_ptr) + off) % NREQ;
            if (!found && req[idx]) begin
                winner = PW'(idx);
                found  = 1'b1;
            end
        end
        valid = found;
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// rtl/regbank_write_arbiter.sv - round-robin arbiter sharing the write port of a register bank
module regbank_write_arbiter
    import regbank_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NREGS = 8,
    parameter int AW    = 3,
    parameter int DW    = REG_DW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]  gnt,
    output logic [NREGS-1:0] reg_en,
    output logic [DW-1:0]    reg_din,
    output logic             addr_err,
    output logic             busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t               state;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        win;
    logic                 win_valid;
    logic [AW-1:0]        sel_addr;
    logic [DW-1:0]        sel_data;
    logic [MAX_REGS-1:0]  dec_full;
    logic [NREGS-1:0]     en_next;
    logic                 err_next;
    logic [NREQ-1:0]      gnt_next;
    logic [PW-1:0]        ptr_next;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (win),
        .valid  (win_valid)
    );

    // An out-of-range index decodes to a bit above NREGS: no enable, error flag instead.
    always_comb begin
        sel_addr     = req_addr[int'(win)*AW +: AW];
        sel_data     = req_data[int'(win)*DW +: DW];
        dec_full     = onehot_dec(9'(sel_addr));
        en_next      = dec_full[NREGS-1:0];
        err_next     = |dec_full[MAX_REGS-1:NREGS];
        gnt_next     = '0;
        gnt_next[win] = 1'b1;
        ptr_next     = (int'(win) == NREQ-1) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            gnt      <= '0;
            reg_en   <= '0;
            reg_din  <= '0;
            addr_err <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        gnt      <= gnt_next;
                        reg_en   <= en_next;
                        reg_din  <= sel_data;
                        addr_err <= err_next;
                        rr_ptr   <= ptr_next;
                        busy     <= 1'b1;
                        state    <= ST_GRANT;
                    end else begin
                        gnt      <= '0;
                        reg_en   <= '0;
                        addr_err <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // reg_din holds so the bank sees stable data around the enable edge.
                    gnt      <= '0;
                    reg_en   <= '0;
                    addr_err <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb/tb_regbank_write_arbiter.sv - scoreboard bench for regbank_write_arbiter (NREQ=4, NREGS=6)
module tb_regbank_write_arbiter;

    localparam int NREQ  = 4;
    localparam int NREGS = 6;
    localparam int AW    = 3;
    localparam int DW    = 10;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      gnt;
    logic [NREGS-1:0]     reg_en;
    logic [DW-1:0]        reg_din;
    logic                 addr_err;
    logic                 busy;

    typedef struct packed {
        logic [NREQ-1:0]  gnt;
        logic [NREGS-1:0] en;
        logic [DW-1:0]    din;
        logic             err;
    } exp_t;

    exp_t        exp_q[$];
    int          gnt_cyc[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cycle   = 0;
    bit          track   = 1'b0;
    logic [DW-1:0] bank [NREGS];
    logic [DW-1:0] bank_exp [NREGS];

    regbank_write_arbiter #(
        .NREQ  (NREQ),
        .NREGS (NREGS),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .reg_en   (reg_en),
        .reg_din  (reg_din),
        .addr_err (addr_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Enable-gated register bank sharing the arbiter reset.
    always @(posedge clk) begin
        for (int k = 0; k < NREGS; k++) begin
            if (reset)          bank[k] <= '0;
            else if (reg_en[k]) bank[k] <= reg_din;
        end
    end

    function automatic exp_t mk(input int r, input logic [NREGS-1:0] en, input int din, input bit err);
        exp_t e;
        e.gnt = '0;
        e.gnt[r] = 1'b1;
        e.en  = en;
        e.din = DW'(din);
        e.err = err;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic set_src(input int i, input int addr, input int data);
        req_addr[i*AW +: AW] = AW'(addr);
        req_data[i*DW +: DW] = DW'(data);
    endtask

    // Hold mask for exactly ngr grant windows, then drop in the last gnt cycle.
    task automatic run(input logic [NREQ-1:0] mask, input int ngr);
        @(posedge clk);
        #1 req = mask;
        repeat (2*ngr - 1) @(posedge clk);
        #1 req = '0;
        repeat (2) @(posedge clk);
    endtask

    // Monitor: invariants every cycle, scoreboard pop whenever a grant is presented.
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (cycle > 0) begin
            n_tests++;
            if (!$onehot0(gnt) || !$onehot0(reg_en) || (reg_en != 0 && gnt == 0) || (busy != (gnt != 0))) begin
                n_fail++;
                $display("FAIL invariant: gnt=%b reg_en=%b busy=%b", gnt, reg_en, busy);
            end
            if (busy || gnt != 0 || reg_en != 0 || addr_err) begin
                if (track) gnt_cyc.push_back(cycle);
                got = '{gnt: gnt, en: reg_en, din: reg_din, err: addr_err};
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_grant: gnt=%b reg_en=%b din=%0d err=%b", gnt, reg_en, reg_din, addr_err);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL grant: got gnt=%b en=%b din=%0d err=%b expected gnt=%b en=%b din=%0d err=%b",
                                 got.gnt, got.en, got.din, got.err, e.gnt, e.en, e.din, e.err);
                    end
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        req_data = '0;

        // Test 1: reset held three cycles, all outputs quiet
        repeat (3) begin
            @(negedge clk);
            check("reset_gnt", int'(gnt), 0);
            check("reset_reg_en", int'(reg_en), 0);
            check("reset_addr_err", int'(addr_err), 0);
            check("reset_busy", int'(busy), 0);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        // Test 2: lone write of 25 to s2
        set_src(0, 2, 25);
        exp_q.push_back(mk(0, 6'b000100, 25, 1'b0));
        run(4'b0001, 1);
        @(negedge clk);
        check("bank_s2_after_write", int'(bank[2]), 25);

        // Test 3: all four requesting from rr_ptr=0
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        set_src(0, 0, 100);
        set_src(1, 1, 101);
        set_src(2, 3, 102);
        set_src(3, 5, 103);
        exp_q.push_back(mk(0, 6'b000001, 100, 1'b0));
        exp_q.push_back(mk(1, 6'b000010, 101, 1'b0));
        exp_q.push_back(mk(2, 6'b001000, 102, 1'b0));
        exp_q.push_back(mk(3, 6'b100000, 103, 1'b0));
        exp_q.push_back(mk(0, 6'b000001, 100, 1'b0));
        track = 1'b1;
        run(4'b1111, 5);
        track = 1'b0;
        check("rr_grant_count", gnt_cyc.size(), 5);
        for (int i = 1; i < gnt_cyc.size(); i++)
            check("rr_grant_spacing", gnt_cyc[i] - gnt_cyc[i-1], 2);

        // Test 4: grant 2 leaves rr_ptr=3, then 0101 wraps to 0 before 2
        exp_q.push_back(mk(2, 6'b001000, 102, 1'b0));
        run(4'b0100, 1);
        exp_q.push_back(mk(0, 6'b000001, 100, 1'b0));
        exp_q.push_back(mk(2, 6'b001000, 102, 1'b0));
        run(4'b0101, 2);

        // Test 5: out-of-range index 7 with six registers
        set_src(1, 7, 99);
        exp_q.push_back('{gnt: 4'b0010, en: 6'b000000, din: 10'd99, err: 1'b1});
        run(4'b0010, 1);
        @(negedge clk);
        bank_exp = '{10'd100, 10'd101, 10'd0, 10'd102, 10'd0, 10'd103};
        for (int k = 0; k < NREGS; k++)
            check($sformatf("bank_s%0d_unchanged", k), int'(bank[k]), int'(bank_exp[k]));

        // Test 6: reset during grant of requester 2 while 3 is pending
        exp_q.push_back(mk(2, 6'b001000, 102, 1'b0));
        exp_q.push_back(mk(0, 6'b000001, 100, 1'b0));
        exp_q.push_back(mk(3, 6'b100000, 103, 1'b0));
        @(posedge clk);
        #1 req = 4'b1100;
        @(posedge clk);
        #1 begin
            reset = 1'b1;
            req   = 4'b1000;
        end
        @(posedge clk);
        #1 begin
            reset = 1'b0;
            req   = 4'b1001;
        end
        @(negedge clk);
        check("reset_in_grant_gnt", int'(gnt), 0);
        check("reset_in_grant_busy", int'(busy), 0);
        check("reset_in_grant_reg_en", int'(reg_en), 0);
        repeat (3) @(posedge clk);
        #1 req = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
